// File: rtl/me_search_ctrl.sv
// me_search_ctrl: full-search sequencer driving the 16-PE distortion array and its comparator.
// Define ME_READY_DELAY_EN to register PEready/VectorX/VectorY by one cycle.
module me_search_ctrl #(
  parameter int unsigned ROW_PITCH = 32,
  parameter int unsigned NPE       = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           CompStart,
  output logic [7:0]     AddressR,
  output logic [9:0]     AddressS1,
  output logic [9:0]     AddressS2,
  output logic [NPE-1:0] S1S2mux,
  output logic [NPE-1:0] NewDist,
  output logic [NPE-1:0] PEready,
  output logic [3:0]     VectorX,
  output logic [3:0]     VectorY
);

  typedef enum logic [1:0] {StIdle, StInit, StRun, StDone} state_e;

`ifdef ME_READY_DELAY_EN
  // One extra RUN cycle flushes the last delayed report before DONE.
  localparam logic [12:0] RunLast = 13'd4112;
`else
  localparam logic [12:0] RunLast = 13'd4111;
`endif

  state_e         state_q, state_d;
  logic [12:0]    c_q, c_d;
  logic           done_q, done_d;

  logic           run;
  logic [3:0]     v, r, k;
  logic [4:0]     row_s1, row_s2;
  logic [NPE-1:0] pe_ready_c;
  logic [3:0]     vec_x_c, vec_y_c;

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: if (start) state_d = StInit;
      StInit: begin
        c_d     = '0;
        state_d = StRun;
      end
      StRun: begin
        c_d = c_q + 13'd1;
        if (c_q == RunLast) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StDone: if (start) state_d = StInit;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      c_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  assign run       = (state_q == StRun);
  assign busy      = (state_q == StInit) || run;
  assign CompStart = run || (state_q == StDone);
  assign done      = done_q;

  assign v      = c_q[11:8];
  assign r      = c_q[7:4];
  assign k      = c_q[3:0];
  // Window row wraps mod 32; S2 reads the previous row's right half.
  assign row_s1 = {1'b0, v} + {1'b0, r};
  assign row_s2 = row_s1 - 5'd1;

  always_comb begin
    AddressR   = '0;
    AddressS1  = '0;
    AddressS2  = '0;
    S1S2mux    = '0;
    NewDist    = '0;
    pe_ready_c = '0;
    vec_x_c    = '0;
    vec_y_c    = '0;
    if (run) begin
      AddressR  = c_q[7:0];
      AddressS1 = 10'(32'(row_s1) * ROW_PITCH) + 10'(k);
      AddressS2 = 10'(32'(row_s2) * ROW_PITCH) + 10'(NPE) + 10'(k);
      for (int i = 0; i < NPE; i++) begin
        S1S2mux[i]    = (int'(k) >= i);
        NewDist[i]    = (c_q[7:0] == 8'(i)) && !c_q[12];
        pe_ready_c[i] = (c_q[7:0] == 8'(i)) && (c_q[12:8] != 5'd0);
      end
      if (|pe_ready_c) begin
        vec_x_c = k;
        vec_y_c = c_q[11:8] - 4'd1;
      end
    end
  end

`ifdef ME_READY_DELAY_EN
  logic [NPE-1:0] pe_ready_q, pe_ready_d;
  logic [3:0]     vec_x_q, vec_x_d, vec_y_q, vec_y_d;

  always_comb begin
    pe_ready_d = pe_ready_c;
    vec_x_d    = vec_x_c;
    vec_y_d    = vec_y_c;
    if (state_q == StInit) begin
      pe_ready_d = '0;
      vec_x_d    = '0;
      vec_y_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_ready_q <= '0;
      vec_x_q    <= '0;
      vec_y_q    <= '0;
    end else begin
      pe_ready_q <= pe_ready_d;
      vec_x_q    <= vec_x_d;
      vec_y_q    <= vec_y_d;
    end
  end

  assign PEready = pe_ready_q;
  assign VectorX = vec_x_q;
  assign VectorY = vec_y_q;
`else
  assign PEready = pe_ready_c;
  assign VectorX = vec_x_c;
  assign VectorY = vec_y_c;
`endif

endmodule

// File: tb/tb_me_search_ctrl.sv
// Self-checking bench for me_search_ctrl: hand vectors plus a cycle-level reference model.
module tb_me_search_ctrl;

`ifdef ME_READY_DELAY_EN
  localparam bit DELAY   = 1'b1;
  localparam int RUN_LEN = 4113;
`else
  localparam bit DELAY   = 1'b0;
  localparam int RUN_LEN = 4112;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic        busy, done, CompStart;
  logic [7:0]  AddressR;
  logic [9:0]  AddressS1, AddressS2;
  logic [15:0] S1S2mux, NewDist, PEready;
  logic [3:0]  VectorX, VectorY;

  always #5 clk = ~clk;

  me_search_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .CompStart (CompStart),
    .AddressR  (AddressR),
    .AddressS1 (AddressS1),
    .AddressS2 (AddressS2),
    .S1S2mux   (S1S2mux),
    .NewDist   (NewDist),
    .PEready   (PEready),
    .VectorX   (VectorX),
    .VectorY   (VectorY)
  );

  typedef struct packed {
    logic busy, done, comp;
    logic [7:0]  ar;
    logic [9:0]  s1, s2;
    logic [15:0] mux, nd, pr;
    logic [3:0]  vx, vy;
  } out_t;

  out_t act;
  assign act = {busy, done, CompStart, AddressR, AddressS1, AddressS2,
                S1S2mux, NewDist, PEready, VectorX, VectorY};

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  // Reference model: phase 0 idle, 1 init, 2 run (n = cycles into run), 3 done.
  int m_phase = 0, m_n = 0;
  bit m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_n = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      case (m_phase)
        0: if (start) m_phase = 1;
        1: begin m_phase = 2; m_n = 0; end
        2: if (m_n == RUN_LEN - 1) begin m_phase = 3; m_done = 1'b1; end else m_n++;
        3: if (start) m_phase = 1;
        default: m_phase = 0;
      endcase
    end
  end

  function automatic out_t expect_out(int ph, int n, bit dn);
    out_t e;
    int v, r, k, p;
    e = '0;
    e.busy = (ph == 1 || ph == 2);
    e.done = dn;
    e.comp = (ph >= 2);
    if (ph == 2) begin
      k = n % 16; r = (n / 16) % 16; v = (n / 256) % 16;
      e.ar = 8'(n % 256);
      e.s1 = 10'(((v + r) % 32) * 32 + k);
      e.s2 = 10'(((v + r + 31) % 32) * 32 + 16 + k);
      for (int i = 0; i < 16; i++) e.mux[i] = (k >= i);
      if (n < 4096 && n % 256 < 16) e.nd[n % 256] = 1'b1;
      p = DELAY ? n - 1 : n;
      if (p >= 256 && p % 256 < 16) begin
        e.pr[p % 256] = 1'b1;
        e.vx = 4'(p % 16);
        e.vy = 4'((p / 256 + 15) % 16);
      end
    end
    return e;
  endfunction

  int bad_cycles = 0, model_checks = 0;

  always @(negedge clk) begin
    out_t e;
    e = expect_out(m_phase, m_n, m_done);
    model_checks++;
    if (act !== e) begin
      bad_cycles++;
      if (bad_cycles <= 5)
        $display("model diverges at %0t: dut=%h model=%h", $time, act, e);
    end
  end

  bit rand_start = 1'b0;
  int pr_cnt, run_cyc, done_cnt;
  int seen[256];

  task automatic clear_counts();
    pr_cnt = 0; run_cyc = 0; done_cnt = 0;
    for (int i = 0; i < 256; i++) seen[i] = 0;
  endtask

  // Advance to the next falling edge; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_start) start = 1'($urandom_range(0, 1));
    @(negedge clk);
    pr_cnt += $countones(PEready);
    if (PEready != 16'h0) seen[{VectorY, VectorX}]++;
    if (busy && CompStart) run_cyc++;
    if (done) done_cnt++;
  endtask

  task automatic wait_run(input int c);
    int budget = 5000;
    while (!(m_phase == 2 && m_n == c) && budget > 0) begin
      tick();
      budget--;
    end
    check($sformatf("reach_c%0d", c), 128'(m_phase == 2 && m_n == c), 128'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  typedef struct {
    int          c;
    logic [7:0]  ar;
    logic [9:0]  s1, s2;
    logic [15:0] mux, nd, pr;
    logic [3:0]  vx, vy;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int nbad, budget;
    tbl[0] = '{0,    8'd0,   10'd0,   10'd1008, 16'h0001, 16'h0001, 16'h0000, 4'd0,  4'd0};
    tbl[1] = '{15,   8'd15,  10'd15,  10'd1023, 16'hFFFF, 16'h8000, 16'h0000, 4'd0,  4'd0};
    tbl[2] = '{17,   8'd17,  10'd33,  10'd17,   16'h0003, 16'h0000, 16'h0000, 4'd0,  4'd0};
    tbl[3] = '{259,  8'd3,   10'd35,  10'd19,   16'h000F, 16'h0008, 16'h0008, 4'd3,  4'd0};
    tbl[4] = '{511,  8'd255, 10'd527, 10'd511,  16'hFFFF, 16'h0000, 16'h0000, 4'd0,  4'd0};
    tbl[5] = '{1000, 8'd232, 10'd552, 10'd536,  16'h01FF, 16'h0000, 16'h0000, 4'd0,  4'd0};
    tbl[6] = '{3850, 8'd10,  10'd490, 10'd474,  16'h07FF, 16'h0400, 16'h0400, 4'd10, 4'd14};
    tbl[7] = '{4094, 8'd254, 10'd974, 10'd958,  16'h7FFF, 16'h0000, 16'h0000, 4'd0,  4'd0};
    tbl[8] = '{4096, 8'd0,   10'd0,   10'd1008, 16'h0001, 16'h0000, 16'h0001, 4'd0,  4'd15};
    tbl[9] = '{4111, 8'd15,  10'd15,  10'd1023, 16'hFFFF, 16'h0000, 16'h8000, 4'd15, 4'd15};

    rst_n = 1'b0;
    start = 1'b0;
    clear_counts();
    repeat (5) begin
      tick();
      check("reset_hold", act, '0);
    end
    rst_n = 1'b1;
    repeat ($urandom_range(1, 4)) tick();
    check("idle_quiet", act, '0);

    // First search: hand vectors, start toggling randomly throughout RUN.
    clear_counts();
    pulse_start();
    check("init_state", {busy, CompStart, NewDist, PEready}, {1'b1, 1'b0, 16'h0, 16'h0});
    rand_start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_run(tbl[i].c);
      check($sformatf("c%0d_addr", tbl[i].c),
            {AddressR, AddressS1, AddressS2, S1S2mux, NewDist, CompStart},
            {tbl[i].ar, tbl[i].s1, tbl[i].s2, tbl[i].mux, tbl[i].nd, 1'b1});
      if (DELAY) tick();
      check($sformatf("c%0d_ready", tbl[i].c), {PEready, VectorX, VectorY},
            {tbl[i].pr, tbl[i].vx, tbl[i].vy});
    end
    rand_start = 1'b0;
    start = 1'b0;
    tick();
    check("done_pulse", {done, busy, CompStart}, {1'b1, 1'b0, 1'b1});
    tick();
    check("done_hold", {done, busy, CompStart, PEready}, {1'b0, 1'b0, 1'b1, 16'h0});
    check("pe_ready_total", 128'(pr_cnt), 128'd256);
    nbad = 0;
    for (int i = 0; i < 256; i++) if (seen[i] != 1) nbad++;
    check("vectors_once", 128'(nbad), 128'd0);
    check("run_length", 128'(run_cyc), 128'(RUN_LEN));
    check("done_count", 128'(done_cnt), 128'd1);

    // Restart from DONE, abort with reset at c=1000.
    clear_counts();
    pulse_start();
    check("restart_init", {busy, CompStart}, {1'b1, 1'b0});
    rand_start = 1'b1;
    wait_run(1000);
    #2 rst_n = 1'b0;
    #1 check("abort_zero", act, '0);
    rand_start = 1'b0;
    start = 1'b0;
    repeat (3) begin
      tick();
      check("abort_hold", act, '0);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    check("no_done_after_abort", 128'(done_cnt), 128'd0);

    // Full search after the abort.
    clear_counts();
    pulse_start();
    rand_start = 1'b1;
    budget = 5000;
    while (!done && budget > 0) begin
      tick();
      budget--;
    end
    check("done_seen", 128'(done), 128'd1);
    check("full_run_length", 128'(run_cyc), 128'(RUN_LEN));
    check("full_pe_ready_total", 128'(pr_cnt), 128'd256);

    // Random episodes: random start activity, reset at random points.
    repeat (3) begin
      repeat ($urandom_range(200, 4500)) tick();
      #2 rst_n = 1'b0;
      #1 check("rand_reset_zero", act, '0);
      tick();
      rst_n = 1'b1;
    end
    rand_start = 1'b0;
    start = 1'b0;
    tick();

    check("model_agreement", 128'(bad_cycles), 128'd0);
    check("model_coverage", 128'(model_checks > 10000), 128'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
